stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_out_reg.sv | 73 +++++++
 rtl/stream_demux.sv | 100 ++++++++++
 tb/tb_stream_demux.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/demux_out_reg.sv
// Single output register stage: holds one beat plus its channel and
// exposes per-channel valid with a pass-through ready toward the input.
module demux_out_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  input  logic [SELW-1:0]  ld_ch,
  input  logic [NCH-1:0]   out_ready,
  output logic             in_ready_c,
  output logic [NCH-1:0]   out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int unsigned NPAD = 1 << SELW;

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [NPAD-1:0]  rdy_pad;
  logic             take;

  // Pad ready so any ch_q value indexes in range.
  assign rdy_pad    = NPAD'(out_ready);
  assign take       = vld_q & rdy_pad[ch_q];
  assign in_ready_c = ~vld_q | rdy_pad[ch_q];

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    ch_d   = ch_q;
    if (take) vld_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      data_d = ld_data;
      last_d = ld_last;
      ch_d   = ld_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      ch_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      ch_q   <= ch_d;
    end
  end

  always_comb begin
    out_valid = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      out_valid[i] = vld_q && (ch_q == SELW'(i));
    end
  end

  assign out_data = data_q;
  assign out_last = last_q;

endmodule

// File: rtl/stream_demux.sv
// Valid/ready stream demultiplexer: per-beat or per-packet routing to
// NCH channels, dropping and counting beats with an out-of-range route.
module stream_demux
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCH    = 4,
  parameter int unsigned PACKET = 0,
  localparam int unsigned SELW  = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [WIDTH-1:0]      IN_DATA,
  input  logic [SELW-1:0]       IN_SEL,
  input  logic                  IN_LAST,
  output logic [NCH-1:0]        OUT_VALID,
  input  logic [NCH-1:0]        OUT_READY,
  output logic [WIDTH-1:0]      OUT_DATA,
  output logic                  OUT_LAST,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  localparam logic [SELW:0]           NCH_LIM = (SELW + 1)'(NCH);
  localparam logic [DROP_CNT_W-1:0]   CNT_MAX = '1;

  state_e                state_q, state_d;
  logic [SELW-1:0]       route_q, route_d;
  logic [DROP_CNT_W-1:0] cnt_q, cnt_d;

  logic [SELW-1:0] route_c;
  logic            route_ok_c;
  logic            accept_c;
  logic            load_c;
  logic            drop_c;
  logic            in_ready_c;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      route_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      cnt_q   <= cnt_d;
    end
  end

  // Route latches on the first beat of a packet; LAST returns to IDLE.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    cnt_d   = cnt_q;
    if (drop_c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + DROP_CNT_W'(1);
    if ((PACKET != 0) && accept_c) begin
      unique case (state_q)
        ST_IDLE: begin
          route_d = IN_SEL;
          if (!IN_LAST) state_d = route_ok_c ? ST_BUSY : ST_DROP;
        end
        ST_BUSY, ST_DROP: begin
          if (IN_LAST) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    route_c    = (state_q == ST_IDLE) ? IN_SEL : route_q;
    route_ok_c = {1'b0, route_c} < NCH_LIM;
    accept_c   = IN_VALID & in_ready_c;
    load_c     = accept_c & route_ok_c;
    drop_c     = accept_c & ~route_ok_c;
  end

  demux_out_reg #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SELW  (SELW)
  ) u_out_reg (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load       (load_c),
    .ld_data    (IN_DATA),
    .ld_last    (IN_LAST),
    .ld_ch      (route_c),
    .out_ready  (OUT_READY),
    .in_ready_c (in_ready_c),
    .out_valid  (OUT_VALID),
    .out_data   (OUT_DATA),
    .out_last   (OUT_LAST)
  );

  assign IN_READY = in_ready_c;
  assign DROP_CNT = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: per-beat, per-packet and 3-channel
// configurations checked against hand-computed expectations.
module tb_stream_demux;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PACKET=0, NCH=4
  logic       a_vld, a_rdy, a_last, a_olast;
  logic [7:0] a_data, a_odata;
  logic [1:0] a_sel;
  logic [3:0] a_ov, a_ordy;
  logic [15:0] a_cnt;

  // PACKET=1, NCH=4
  logic       b_vld, b_rdy, b_last, b_olast;
  logic [7:0] b_data, b_odata;
  logic [1:0] b_sel;
  logic [3:0] b_ov, b_ordy;
  logic [15:0] b_cnt;

  // PACKET=1, NCH=3
  logic       c_vld, c_rdy, c_last, c_olast;
  logic [7:0] c_data, c_odata;
  logic [1:0] c_sel;
  logic [2:0] c_ov, c_ordy;
  logic [15:0] c_cnt;

  stream_demux #(.WIDTH(8), .NCH(4), .PACKET(0)) u_a (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(a_vld), .IN_READY(a_rdy),
    .IN_DATA(a_data), .IN_SEL(a_sel), .IN_LAST(a_last), .OUT_VALID(a_ov),
    .OUT_READY(a_ordy), .OUT_DATA(a_odata), .OUT_LAST(a_olast), .DROP_CNT(a_cnt)
  );

  stream_demux #(.WIDTH(8), .NCH(4), .PACKET(1)) u_b (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(b_vld), .IN_READY(b_rdy),
    .IN_DATA(b_data), .IN_SEL(b_sel), .IN_LAST(b_last), .OUT_VALID(b_ov),
    .OUT_READY(b_ordy), .OUT_DATA(b_odata), .OUT_LAST(b_olast), .DROP_CNT(b_cnt)
  );

  stream_demux #(.WIDTH(8), .NCH(3), .PACKET(1)) u_c (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(c_vld), .IN_READY(c_rdy),
    .IN_DATA(c_data), .IN_SEL(c_sel), .IN_LAST(c_last), .OUT_VALID(c_ov),
    .OUT_READY(c_ordy), .OUT_DATA(c_odata), .OUT_LAST(c_olast), .DROP_CNT(c_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic [3:0] ordy;
    logic       e_rdy;
    logic [3:0] e_ov;
    logic [7:0] e_data;
    logic       e_last;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // Packet-mode beat on u_b, then check the registered result one cycle later.
  task automatic b_beat(input logic [7:0] d, input logic [1:0] s, input logic l,
                        input logic [3:0] e_ov, input string name);
    b_vld = 1'b1; b_data = d; b_sel = s; b_last = l;
    @(negedge clk);
    b_vld = 1'b0;
    chk({name, "_ov"}, 32'(b_ov), 32'(e_ov));
    chk({name, "_data"}, 32'(b_odata), 32'(d));
    chk({name, "_last"}, 32'(b_olast), 32'(l));
  endtask

  task automatic c_beat(input logic [7:0] d, input logic [1:0] s, input logic l,
                        input logic [2:0] e_ov, input logic [15:0] e_cnt, input string name);
    c_vld = 1'b1; c_data = d; c_sel = s; c_last = l;
    #1 chk({name, "_rdy"}, 32'(c_rdy), 32'd1);
    @(negedge clk);
    c_vld = 1'b0;
    chk({name, "_ov"}, 32'(c_ov), 32'(e_ov));
    chk({name, "_cnt"}, 32'(c_cnt), 32'(e_cnt));
  endtask

  initial begin
    // vld sel data last ordy | rdy ov data last (state before the edge)
    vecs[0] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 8'hA1, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 2'd0, 8'hB2, 1'b0, 4'b1111, 1'b1, 4'b0100, 8'hA1, 1'b0};
    vecs[3] = '{1'b1, 2'd2, 8'hC3, 1'b1, 4'b1111, 1'b1, 4'b0001, 8'hB2, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 8'hD4, 1'b0, 4'b1011, 1'b0, 4'b0100, 8'hC3, 1'b1};
    vecs[5] = '{1'b1, 2'd1, 8'hD4, 1'b0, 4'b1011, 1'b0, 4'b0100, 8'hC3, 1'b1};
    vecs[6] = '{1'b1, 2'd1, 8'hD4, 1'b0, 4'b0001, 1'b0, 4'b0100, 8'hC3, 1'b1};
    vecs[7] = '{1'b1, 2'd1, 8'hD4, 1'b0, 4'b1111, 1'b1, 4'b0100, 8'hC3, 1'b1};
    vecs[8] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0010, 8'hD4, 1'b0};
    vecs[9] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'hD4, 1'b0};

    rst_n = 1'b0;
    a_vld = 0; a_data = 0; a_sel = 0; a_last = 0; a_ordy = 4'b1111;
    b_vld = 0; b_data = 0; b_sel = 0; b_last = 0; b_ordy = 4'b1111;
    c_vld = 0; c_data = 0; c_sel = 0; c_last = 0; c_ordy = 3'b111;
    repeat (2) @(negedge clk);
    chk("rst_ov", 32'(b_ov), 32'd0);
    chk("rst_rdy", 32'(b_rdy), 32'd1);
    chk("rst_cnt", 32'(c_cnt), 32'd0);
    rst_n = 1'b1;

    // Per-beat routing, back-to-back, backpressure and drain
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_vld = vecs[i].vld; a_sel = vecs[i].sel; a_data = vecs[i].data;
      a_last = vecs[i].last; a_ordy = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(a_rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_ov", i), 32'(a_ov), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_data", i), 32'(a_odata), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_last", i), 32'(a_olast), 32'(vecs[i].e_last));
    end
    chk("a_cnt", 32'(a_cnt), 32'd0);

    // Packet route held despite IN_SEL changing mid-packet
    @(negedge clk);
    b_beat(8'h11, 2'd1, 1'b0, 4'b0010, "pk1");
    b_beat(8'h22, 2'd3, 1'b0, 4'b0010, "pk2");
    b_beat(8'h33, 2'd3, 1'b1, 4'b0010, "pk3");
    b_beat(8'h44, 2'd3, 1'b1, 4'b1000, "pk_single");

    // Invalid route in NCH=3: whole packet dropped, then back to IDLE
    c_beat(8'h01, 2'd3, 1'b0, 3'b000, 16'd1, "drop1");
    c_beat(8'h02, 2'd0, 1'b0, 3'b000, 16'd2, "drop2");
    c_beat(8'h03, 2'd3, 1'b0, 3'b000, 16'd3, "drop3");
    c_beat(8'h04, 2'd3, 1'b1, 3'b000, 16'd4, "drop4");
    c_beat(8'h55, 2'd0, 1'b1, 3'b001, 16'd4, "after_drop");
    chk("after_drop_data", 32'(c_odata), 32'h55);

    // Reset mid-packet with a held beat
    b_ordy = 4'b1011;
    b_beat(8'h66, 2'd2, 1'b0, 4'b0100, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(b_ov), 32'd0);
    chk("mid_rst_data", 32'(b_odata), 32'd0);
    chk("mid_rst_rdy", 32'(b_rdy), 32'd1);
    chk("mid_rst_cnt", 32'(c_cnt), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    b_ordy = 4'b1111;
    b_beat(8'h77, 2'd0, 1'b1, 4'b0001, "post_rst");

    // Saturation: 65535 drops reach the ceiling, one more must not wrap
    c_vld = 1'b1; c_sel = 2'd3; c_last = 1'b1; c_data = 8'hEE;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    c_vld = 1'b0;
    chk("sat_reach", 32'(c_cnt), 32'hFFFF);
    c_beat(8'hEF, 2'd3, 1'b1, 3'b000, 16'hFFFF, "sat_hold");
    c_beat(8'h5A, 2'd2, 1'b1, 3'b100, 16'hFFFF, "sat_valid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
